// File: rtl/compare_seq_bitwise.sv
// Sequential magnitude comparator: scans two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, unsigned or two's-complement, with optional early exit.
module compare_seq_bitwise #(
    parameter int WIDTH      = 16,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_GT   = 2'b01;
    localparam logic [1:0] R_LT   = 2'b10;
    localparam logic [1:0] R_EQ   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [1:0]       rec_q, rec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       result_q, result_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [1:0]       rec_next;
    logic             finish;

    assign chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        rec_d    = rec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        rec_next = rec_q;
        finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_d      = a ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    b_d      = b ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    idx_d    = IDX_TOP;
                    rec_d    = R_NONE;
                    result_d = R_NONE;
                    busy_d   = 1'b1;
                    state_d  = S_CMP;
                end
            end

            S_CMP: begin
                if (rec_q == R_NONE && chunk_a != chunk_b) begin
                    rec_next = (chunk_a > chunk_b) ? R_GT : R_LT;
                end
                if (EARLY_EXIT != 0 && rec_next != R_NONE) begin
                    finish = 1'b1;
                end
                if (idx_q == '0) begin
                    finish = 1'b1;
                    if (rec_next == R_NONE) begin
                        rec_next = R_EQ;
                    end
                end
                rec_d = rec_next;
                if (finish) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = rec_next;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end

            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            rec_q    <= R_NONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= R_NONE;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            rec_q    <= rec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_compare_seq_bitwise.sv
// Bench for compare_seq_bitwise: directed and random compares on four
// configurations, checked against an arithmetic reference model.
module tb_compare_seq_bitwise;

    logic        clk;
    logic        rst_n;
    logic        sm;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic [3:0]  st;
    logic [3:0]  bsy;
    logic [3:0]  dn;
    logic [1:0]  rs [4];

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: W16/C4 early exit, 1: W16/C4 fixed latency, 2: W4/C1, 3: W16/C16
    compare_seq_bitwise #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) u_e (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm), .a(a16), .b(b16),
        .busy(bsy[0]), .done(dn[0]), .result(rs[0]));
    compare_seq_bitwise #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) u_n (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm), .a(a16), .b(b16),
        .busy(bsy[1]), .done(dn[1]), .result(rs[1]));
    compare_seq_bitwise #(.WIDTH(4), .CHUNK(1), .EARLY_EXIT(1)) u_4 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm), .a(a4), .b(b4),
        .busy(bsy[2]), .done(dn[2]), .result(rs[2]));
    compare_seq_bitwise #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1)) u_w (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .signed_mode(sm), .a(a16), .b(b16),
        .busy(bsy[3]), .done(dn[3]), .result(rs[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_res(input int av, input int bv, input logic s, input int w);
        int va, vb;
        va = av & ((1 << w) - 1);
        vb = bv & ((1 << w) - 1);
        if (s && va >= (1 << (w - 1))) va = va - (1 << w);
        if (s && vb >= (1 << (w - 1))) vb = vb - (1 << w);
        if (va > vb) return 2'b01;
        if (va < vb) return 2'b10;
        return 2'b11;
    endfunction

    // Chunks examined: position (1 = MSB chunk) of the first differing chunk.
    function automatic int ref_k(input int av, input int bv, input int w, input int c, input int ee);
        int n, cm, sh;
        n  = w / c;
        cm = (1 << c) - 1;
        if (ee == 0) return n;
        for (int i = 1; i <= n; i++) begin
            sh = w - i * c;
            if (((av >> sh) & cm) != ((bv >> sh) & cm)) return i;
        end
        return n;
    endfunction

    // Entered and left at posedge+1 with the selected DUT idle; exits on the
    // first idle cycle after done, so consecutive calls run back-to-back.
    task automatic do_cmp(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic smv, input string tag);
        int w, c, ee, k, cyc, ai, bi;
        logic [1:0] exp;
        case (sel)
            0:       begin w = 16; c = 4;  ee = 1; end
            1:       begin w = 16; c = 4;  ee = 0; end
            2:       begin w = 4;  c = 1;  ee = 1; end
            default: begin w = 16; c = 16; ee = 1; end
        endcase
        ai  = int'(av) & ((1 << w) - 1);
        bi  = int'(bv) & ((1 << w) - 1);
        exp = ref_res(ai, bi, smv, w);
        k   = ref_k(ai, bi, w, c, ee);
        if (sel == 2) begin a4 = av[3:0]; b4 = bv[3:0]; end
        else begin a16 = av; b16 = bv; end
        sm      = smv;
        st[sel] = 1'b1;
        @(posedge clk); #1;
        st[sel] = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        a4  = 4'($urandom);  b4  = 4'($urandom);
        sm  = 1'($urandom);
        cyc = 1;
        chk($sformatf("%s busy@1", tag), {31'd0, bsy[sel]}, 32'd1);
        while (!dn[sel] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("%s done_cycle", tag), cyc, k + 1);
        chk($sformatf("%s result", tag), {30'd0, rs[sel]}, {30'd0, exp});
        chk($sformatf("%s busy@done", tag), {31'd0, bsy[sel]}, 32'd1);
        @(posedge clk); #1;
        chk($sformatf("%s done_pulse", tag), {31'd0, dn[sel]}, 32'd0);
        chk($sformatf("%s busy_after", tag), {31'd0, bsy[sel]}, 32'd0);
        chk($sformatf("%s result_hold", tag), {30'd0, rs[sel]}, {30'd0, exp});
    endtask

    initial begin
        int dcnt, dcyc, r;
        logic [15:0] ra, rb;

        rst_n = 1'b0; st = '0; sm = 1'b0;
        a16 = '0; b16 = '0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset busy%0d", i), {31'd0, bsy[i]}, 32'd0);
            chk($sformatf("reset done%0d", i), {31'd0, dn[i]}, 32'd0);
            chk($sformatf("reset result%0d", i), {30'd0, rs[i]}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmp(0, 16'h1234, 16'h1235, 1'b0, "t1_lsb_diff");
        do_cmp(0, 16'h8000, 16'h7FFF, 1'b0, "t2_unsigned");
        do_cmp(0, 16'h8000, 16'h7FFF, 1'b1, "t2_signed");
        do_cmp(0, 16'hBEEF, 16'hBEEF, 1'b0, "t3_equal");
        do_cmp(1, 16'hF000, 16'h0000, 1'b0, "t3_fixed_lat");
        do_cmp(1, 16'hBEEF, 16'hBEEF, 1'b1, "t3_fixed_eq");
        do_cmp(3, 16'h0001, 16'hFFFF, 1'b1, "wide_signed");
        do_cmp(3, 16'h0001, 16'hFFFF, 1'b0, "wide_unsigned");

        // Second start during a running compare must be ignored.
        a16 = 16'h1234; b16 = 16'h1235; sm = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0; dcnt = 0; dcyc = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin a16 = 16'hFFFF; b16 = 16'h0000; sm = 1'b1; st[0] = 1'b1; end
            if (c == 3) st[0] = 1'b0;
            if (dn[0]) begin
                dcnt++;
                dcyc = c;
                chk("t4 result", {30'd0, rs[0]}, 32'd2);
            end
            @(posedge clk); #1;
        end
        chk("t4 done_count", dcnt, 1);
        chk("t4 done_cycle", dcyc, 5);

        // Reset mid-compare aborts with no done pulse.
        a16 = 16'h0F00; b16 = 16'h0E00; sm = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t5 busy", {31'd0, bsy[0]}, 32'd0);
        chk("t5 done", {31'd0, dn[0]}, 32'd0);
        chk("t5 result", {30'd0, rs[0]}, 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dn[0]) dcnt++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (dn[0]) dcnt++;
        end
        chk("t5 no_done", dcnt, 0);
        do_cmp(0, 16'h0F00, 16'h0E00, 1'b0, "t5_fresh");

        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            r  = $urandom_range(0, 4);
            if (r == 4) rb = ra;
            else rb = ra ^ 16'($urandom_range(1, 15) << (4 * r));
            if ($urandom_range(0, 3) == 0) rb = 16'($urandom);
            do_cmp(i % 4 == 2 ? 0 : i % 4, ra, rb, 1'($urandom), $sformatf("rnd%0d", i));
        end

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    do_cmp(2, 16'(i), 16'(j), 1'(s), $sformatf("x4 s%0d a%0d b%0d", s, i, j));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
